// File: rtl/yarp_dmem_responder.sv
// yarp_dmem_responder: data-memory responder with byte/half/word stores, pipelined loads, error flagging and stats
module yarp_dmem_responder #(
  parameter int DEPTH    = 1024,
  parameter int READ_LAT = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        data_mem_req,
  input  logic [31:0] data_mem_addr,
  input  logic [1:0]  data_mem_byte_en,
  input  logic        data_mem_wr,
  input  logic [31:0] data_mem_wr_data,
  output logic [31:0] data_mem_rd_data,
  output logic        data_mem_rd_valid,
  output logic        misalign_err,
  output logic [31:0] err_addr,
  output logic [15:0] rd_cnt,
  output logic [15:0] wr_cnt
);
  localparam int AW = $clog2(DEPTH);
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] idx;
  logic          err;
  logic          ld;
  logic          st;
  logic [3:0]    be;
  logic [31:0]   wdata;
  logic          pv [READ_LAT];
  logic [31:0]   pd [READ_LAT];
  assign idx = data_mem_addr[AW+1:2];
  assign ld  = data_mem_req & ~data_mem_wr & ~err;
  assign st  = data_mem_req & data_mem_wr & ~err;
  // Decode size into byte mask, lane-replicated store data and alignment error
  always_comb begin
    err   = (data_mem_byte_en == 2'b10) |
            (data_mem_byte_en == 2'b01 && data_mem_addr[0]) |
            (data_mem_byte_en == 2'b11 && data_mem_addr[1:0] != 2'b00);
    be    = data_mem_byte_en == 2'b00 ? 4'b0001 << data_mem_addr[1:0] :
            data_mem_byte_en == 2'b01 ? (data_mem_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wdata = data_mem_byte_en == 2'b00 ? {4{data_mem_wr_data[7:0]}} :
            data_mem_byte_en == 2'b01 ? {2{data_mem_wr_data[15:0]}} : data_mem_wr_data;
  end
  // Array write at the accepting edge; a request seen during reset is dropped
  always_ff @(posedge clk) begin
    if (reset_n && st)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
  end
  // Load pipeline: erroring loads still flow through as a valid zero word
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < READ_LAT; i++) begin
        pv[i] <= 1'b0;
        pd[i] <= '0;
      end
    end else begin
      pv[0] <= data_mem_req & ~data_mem_wr;
      pd[0] <= ld ? mem[idx] : '0;
      for (int i = 1; i < READ_LAT; i++) begin
        pv[i] <= pv[i-1];
        pd[i] <= pd[i-1];
      end
    end
  end
  assign data_mem_rd_valid = pv[READ_LAT-1];
  assign data_mem_rd_data  = pv[READ_LAT-1] ? pd[READ_LAT-1] : '0;
  // Sticky error capture and saturating access counters
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      misalign_err <= 1'b0;
      err_addr     <= '0;
      rd_cnt       <= '0;
      wr_cnt       <= '0;
    end else begin
      if (data_mem_req && err) begin
        misalign_err <= 1'b1;
        if (!misalign_err) err_addr <= data_mem_addr;
      end
      if (ld && rd_cnt != 16'hFFFF) rd_cnt <= rd_cnt + 16'd1;
      if (st && wr_cnt != 16'hFFFF) wr_cnt <= wr_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_yarp_dmem_responder.sv
// tb_yarp_dmem_responder: directed vector bench for yarp_dmem_responder at READ_LAT 1, 2 and 3
module tb_yarp_dmem_responder;
  logic        clk = 0;
  logic        reset_n = 0;
  logic        req = 0;
  logic [31:0] addr = 0;
  logic [1:0]  be = 0;
  logic        wr = 0;
  logic [31:0] wdata = 0;
  logic [31:0] d1, d2, d3, ea1, ea2, ea3;
  logic        v1, v2, v3, e1, e2, e3;
  logic [15:0] rc1, rc2, rc3, wc1, wc2, wc3;
  int          total = 0;
  int          pass = 0;
  typedef struct {
    logic        wr;
    logic [1:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        v;
    logic [31:0] d;
    logic        e;
    logic [31:0] ea;
    logic [15:0] wc;
    logic [15:0] rc;
  } vec_t;
  vec_t vq[$];

  always #5 clk = ~clk;

  yarp_dmem_responder #(.DEPTH(1024), .READ_LAT(1)) u_l1 (
    .clk(clk), .reset_n(reset_n), .data_mem_req(req), .data_mem_addr(addr),
    .data_mem_byte_en(be), .data_mem_wr(wr), .data_mem_wr_data(wdata),
    .data_mem_rd_data(d1), .data_mem_rd_valid(v1), .misalign_err(e1),
    .err_addr(ea1), .rd_cnt(rc1), .wr_cnt(wc1));
  yarp_dmem_responder #(.DEPTH(1024), .READ_LAT(2)) u_l2 (
    .clk(clk), .reset_n(reset_n), .data_mem_req(req), .data_mem_addr(addr),
    .data_mem_byte_en(be), .data_mem_wr(wr), .data_mem_wr_data(wdata),
    .data_mem_rd_data(d2), .data_mem_rd_valid(v2), .misalign_err(e2),
    .err_addr(ea2), .rd_cnt(rc2), .wr_cnt(wc2));
  yarp_dmem_responder #(.DEPTH(1024), .READ_LAT(3)) u_l3 (
    .clk(clk), .reset_n(reset_n), .data_mem_req(req), .data_mem_addr(addr),
    .data_mem_byte_en(be), .data_mem_wr(wr), .data_mem_wr_data(wdata),
    .data_mem_rd_data(d3), .data_mem_rd_valid(v3), .misalign_err(e3),
    .err_addr(ea3), .rd_cnt(rc3), .wr_cnt(wc3));

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %h want %h", n, act, exp);
  endtask

  task automatic add(input logic w, input logic [1:0] b, input logic [31:0] a, input logic [31:0] wd,
                     input logic v, input logic [31:0] d, input logic e, input logic [31:0] ea,
                     input logic [15:0] wc, input logic [15:0] rc);
    vec_t t;
    t.wr = w; t.be = b; t.addr = a; t.wdata = wd; t.v = v; t.d = d;
    t.e = e; t.ea = ea; t.wc = wc; t.rc = rc;
    vq.push_back(t);
  endtask

  task automatic drive(input logic r, input logic w, input logic [1:0] b, input logic [31:0] a, input logic [31:0] wd);
    req = r; wr = w; be = b; addr = a; wdata = wd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    add(1, 2'b11, 32'h10,       32'hDEADBEEF, 0, 32'h0,        0, 32'h0,  1, 0);
    add(0, 2'b11, 32'h10,       32'h0,        1, 32'hDEADBEEF, 0, 32'h0,  1, 1);
    add(1, 2'b11, 32'h20,       32'h0,        0, 32'h0,        0, 32'h0,  2, 1);
    add(1, 2'b00, 32'h23,       32'h123456AB, 0, 32'h0,        0, 32'h0,  3, 1);
    add(1, 2'b01, 32'h20,       32'hFFFF1234, 0, 32'h0,        0, 32'h0,  4, 1);
    add(0, 2'b11, 32'h20,       32'h0,        1, 32'hAB001234, 0, 32'h0,  4, 2);
    add(1, 2'b01, 32'h22,       32'h00005678, 0, 32'h0,        0, 32'h0,  5, 2);
    add(0, 2'b01, 32'h22,       32'h0,        1, 32'h56781234, 0, 32'h0,  5, 3);
    add(1, 2'b00, 32'h21,       32'h0000005A, 0, 32'h0,        0, 32'h0,  6, 3);
    add(0, 2'b11, 32'h20,       32'h0,        1, 32'h56785A34, 0, 32'h0,  6, 4);
    add(1, 2'b11, 32'h30,       32'h11111111, 0, 32'h0,        0, 32'h0,  7, 4);
    add(1, 2'b01, 32'h31,       32'h0000BEEF, 0, 32'h0,        1, 32'h31, 7, 4);
    add(0, 2'b11, 32'h30,       32'h0,        1, 32'h11111111, 1, 32'h31, 7, 5);
    add(0, 2'b11, 32'h42,       32'h0,        1, 32'h0,        1, 32'h31, 7, 5);
    add(1, 2'b10, 32'h40,       32'hFFFFFFFF, 0, 32'h0,        1, 32'h31, 7, 5);
    add(1, 2'b11, 32'h1004,     32'h12345678, 0, 32'h0,        1, 32'h31, 8, 5);
    add(0, 2'b11, 32'h4,        32'h0,        1, 32'h12345678, 1, 32'h31, 8, 6);
    add(0, 2'b11, 32'h1004,     32'h0,        1, 32'h12345678, 1, 32'h31, 8, 7);
    add(1, 2'b00, 32'h7,        32'h00000099, 0, 32'h0,        1, 32'h31, 9, 7);
    add(0, 2'b11, 32'hFFFFF004, 32'h0,        1, 32'h99345678, 1, 32'h31, 9, 8);

    step();
    step();
    chk("reset valid", {31'b0, v1}, 32'h0);
    chk("reset data", d1, 32'h0);
    chk("reset err", {31'b0, e1}, 32'h0);
    chk("reset err_addr", ea1, 32'h0);
    chk("reset counts", {rc1, wc1}, 32'h0);
    reset_n = 1;
    step();

    foreach (vq[i]) begin
      drive(1, vq[i].wr, vq[i].be, vq[i].addr, vq[i].wdata);
      step();
      chk($sformatf("vec%0d valid", i), {31'b0, v1}, {31'b0, vq[i].v});
      chk($sformatf("vec%0d data", i), d1, vq[i].d);
      chk($sformatf("vec%0d err", i), {31'b0, e1}, {31'b0, vq[i].e});
      chk($sformatf("vec%0d err_addr", i), ea1, vq[i].ea);
      chk($sformatf("vec%0d wr_cnt", i), {16'b0, wc1}, {16'b0, vq[i].wc});
      chk($sformatf("vec%0d rd_cnt", i), {16'b0, rc1}, {16'b0, vq[i].rc});
    end

    for (int k = 0; k < 4; k++) begin
      drive(1, 1, 2'b11, 32'h100 + 32'(4 * k), 32'(k + 1));
      step();
    end
    for (int k = 0; k < 8; k++) begin
      if (k < 4) drive(1, 0, 2'b11, 32'h100 + 32'(4 * k), 32'h0);
      else drive(0, 0, 2'b11, 32'h0, 32'h0);
      step();
      chk($sformatf("lat3 k%0d valid", k), {31'b0, v3}, {31'b0, k >= 2 && k <= 5});
      chk($sformatf("lat3 k%0d data", k), d3, (k >= 2 && k <= 5) ? 32'(k - 1) : 32'h0);
      chk($sformatf("lat1 k%0d data", k), d1, k < 4 ? 32'(k + 1) : 32'h0);
    end

    drive(1, 0, 2'b11, 32'h100, 32'h0);
    step();
    chk("gap load0 valid", {31'b0, v1}, 32'h1);
    drive(1, 1, 2'b11, 32'h200, 32'h77);
    step();
    chk("gap store valid", {31'b0, v1}, 32'h0);
    chk("gap store l2 data", d2, 32'h1);
    drive(1, 0, 2'b11, 32'h104, 32'h0);
    step();
    chk("gap load1 data", d1, 32'h2);
    chk("gap store l2 valid", {31'b0, v2}, 32'h0);
    drive(0, 0, 2'b11, 32'h0, 32'h0);
    step();
    chk("gap load1 l2 data", d2, 32'h2);

    drive(1, 0, 2'b11, 32'h100, 32'h0);
    step();
    chk("rst load l2 early", {31'b0, v2}, 32'h0);
    reset_n = 0;
    drive(1, 1, 2'b11, 32'h104, 32'hCAFEF00D);
    step();
    chk("rst l2 valid", {31'b0, v2}, 32'h0);
    chk("rst l2 data", d2, 32'h0);
    chk("rst l2 err", {31'b0, e2}, 32'h0);
    chk("rst l2 err_addr", ea2, 32'h0);
    chk("rst l2 counts", {rc2, wc2}, 32'h0);
    reset_n = 1;
    drive(0, 0, 2'b11, 32'h0, 32'h0);
    step();
    chk("rst after l2 valid", {31'b0, v2}, 32'h0);
    drive(1, 0, 2'b11, 32'h104, 32'h0);
    step();
    drive(0, 0, 2'b11, 32'h0, 32'h0);
    step();
    chk("rst preserved valid", {31'b0, v2}, 32'h1);
    chk("rst preserved data", d2, 32'h2);
    chk("rst rd_cnt", {16'b0, rc2}, 32'h1);

    drive(1, 1, 2'b11, 32'h200, 32'h0);
    repeat (65534) @(posedge clk);
    step();
    chk("sat wr_cnt max", {16'b0, wc1}, 32'hFFFF);
    step();
    chk("sat wr_cnt hold", {16'b0, wc1}, 32'hFFFF);
    chk("sat rd_cnt", {16'b0, rc1}, 32'h1);
    drive(0, 0, 2'b11, 32'h0, 32'h0);
    step();

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule

// File: doc/yarp_dmem_responder.md
# yarp_dmem_responder

Memory-side responder for the YARP core's data-memory port. It accepts the core's `data_mem_*` requests, performs byte, half and word stores into an internal word-addressed array, and returns read data after a fixed, parameterised latency. It also flags misaligned or reserved-size accesses and keeps access statistics. It sits opposite the core on the data-memory bus, in both the SoC top and the verification harness.

## Interface
- `DEPTH`, 1024: number of 32-bit words; power of two; index = `data_mem_addr[AW+1:2]`, where AW = log2(DEPTH).
- `READ_LAT`, 1: read latency in cycles; legal range 1..4.
- `clk` in 1: single clock; all logic on its rising edge.
- `reset_n` in 1: synchronous, active-low reset, sampled at `posedge clk`.
- `data_mem_req` in 1: access request, valid for one cycle per access.
- `data_mem_addr` in 32: byte address.
- `data_mem_byte_en` in 2: access size. 2'b00 byte, 2'b01 half, 2'b11 word, 2'b10 reserved.
- `data_mem_wr` in 1: 1 = store, 0 = load.
- `data_mem_wr_data` in 32: store data, right-justified. Byte uses [7:0]; half uses [15:0].
- `data_mem_rd_data` out 32: full aligned word for the load; 0 when not valid.
- `data_mem_rd_valid` out 1: one-cycle pulse marking `data_mem_rd_data`.
- `misalign_err` out 1: sticky error flag.
- `err_addr` out 32: address of the first erroring access.
- `rd_cnt` out 16: completed-load count, saturating at 16'hFFFF.
- `wr_cnt` out 16: completed-store count, saturating at 16'hFFFF.

## Operation
- An access is accepted at any rising edge where `data_mem_req`=1. The block has no stall and no backpressure; it can accept one access every cycle.
- **Store:**
  - Shift `wr_data` to lane `addr[1:0]` (byte), or lane `{addr[1],1'b0}` (half).
  - Write only the enabled bytes of word `addr[AW+1:2]`.
  - A word store writes all 4 bytes.
- **Load:**
  - Read the full word at index `addr[AW+1:2]`.
  - Feed it through a READ_LAT-deep pipeline of `{valid, data}` stages.
  - The block does not extract or sign-extend; the core does that.
- **Address wrap:** address bits above AW+1 are ignored, so addresses alias modulo DEPTH*4.
- **Error conditions:**
  - Reserved size 2'b10.
  - Half access with `addr[0]`=1.
  - Word access with `addr[1:0]`≠0.
- **On an erroring access:**
  - No array write.
  - A load still produces an `rd_valid` pulse, with data 0.
  - `misalign_err` sets and holds until reset.
  - `err_addr` latches only the first error.
  - `rd_cnt`/`wr_cnt` do not increment.
- **Counters:** each increments by 1 at acceptance of a non-erroring load or store and saturates at its maximum.
- **Read-after-write:** a load accepted the cycle after a store to the same word returns the new data. This is the natural result of a store completing at the accepting edge.
- **Reset state:**
  - Pipeline valids 0, `data_mem_rd_data` 0, `data_mem_rd_valid` 0.
  - `misalign_err` 0, `err_addr` 0, `rd_cnt` 0, `wr_cnt` 0.
  - Array contents are not reset.
- **Reset mid-operation:** loads in flight are discarded, with no `rd_valid`. A request sampled in the same cycle as `reset_n`=0 is ignored, including its write.

## Timing
- Store: the array is updated at the accepting edge E. Counter and error updates are visible after E.
- Load at edge E: `rd_valid`=1 and data are visible in the cycle after edge E+READ_LAT-1. With READ_LAT=1, that is the cycle following acceptance.
- Back-to-back loads at edges E, E+1 give consecutive `rd_valid` pulses in the same order. No reordering.
- A store between two loads does not disturb the load pipeline. `rd_valid` is low in the slot corresponding to the store.
- `misalign_err` and `err_addr` are registered: visible the cycle after the erroring acceptance.
- Stores have no response signal.

## Test plan
- **Word store then load:** store 0xDEADBEEF at 0x10, then load 0x10 (READ_LAT=1) -> `rd_valid` one cycle later, data 0xDEADBEEF, `wr_cnt`=1, `rd_cnt`=1.
- **Byte and half lanes:**
  - Word 0x00000000 at 0x20.
  - Store byte 0xAB at 0x23, then half 0x1234 at 0x20.
  - Load 0x20 -> 0xAB001234.
- **Misalignment:**
  - Half store at 0x31 -> `misalign_err`=1, `err_addr`=0x31, word unchanged, `wr_cnt` unchanged.
  - A later word load at 0x42 -> data 0 with `rd_valid`; `err_addr` stays 0x31.
- **Latency and pipelining:** READ_LAT=3, loads at edges E..E+3 of words holding 1,2,3,4 -> `rd_valid` high for 4 consecutive cycles starting after edge E+2, data 1,2,3,4.
- **Wrap and saturation:**
  - DEPTH=1024: store at 0x1004, then load 0x4 -> same data.
  - Force `wr_cnt`=0xFFFF via 65535 stores, then one more store -> stays 0xFFFF.
- **Reset mid-operation:** READ_LAT=2, load accepted, then `reset_n`=0 for the next edge -> no `rd_valid`; outputs 0; array contents preserved for later reads.
